// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Purpose  : Parametrised oversampled UART receiver with glitch rejection,
//            parity/framing/overrun reporting and a sticky valid/read handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 baud_clk,
   input  logic                 reset,
   input  logic                 din,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] out,
   output logic                 recieve_flag,
   output logic                 data_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err
);

   localparam int c_CW = $clog2(OVERSAMPLE);
   localparam int c_BW = $clog2(DATA_BITS + 1);

   localparam logic [c_CW-1:0] c_HALF_M1   = c_CW'(OVERSAMPLE / 2 - 1);
   localparam logic [c_CW-1:0] c_FULL_M1   = c_CW'(OVERSAMPLE - 1);
   localparam logic [c_BW-1:0] c_LAST_DATA = c_BW'(DATA_BITS - 1);
   localparam logic [c_BW-1:0] c_LAST_STOP = c_BW'(STOP_BITS - 1);
   localparam logic            c_HAS_PAR   = (PARITY != 0);
   localparam logic            c_ODD       = (PARITY == 1);

   localparam logic [2:0] c_S_IDLE   = 3'd0;
   localparam logic [2:0] c_S_START  = 3'd1;
   localparam logic [2:0] c_S_DATA   = 3'd2;
   localparam logic [2:0] c_S_PARITY = 3'd3;
   localparam logic [2:0] c_S_STOP   = 3'd4;
   localparam logic [2:0] c_S_WAIT   = 3'd5;

   logic [2:0]           r_state;
   logic [2:0]           w_state_next;
   logic                 r_sync1;
   logic                 r_din_s;
   logic [c_CW-1:0]      r_cnt;
   logic [c_BW-1:0]      r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_stop_err;
   logic                 r_perr_pend;
   logic                 r_ferr_pend;
   logic                 r_done;
   logic                 w_sample;
   logic                 w_last_data;
   logic                 w_last_stop;
   logic                 w_frame_now;

   always_ff @(posedge baud_clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_S_IDLE:   if (!r_din_s)    w_state_next = c_S_START;
         c_S_START:  if (w_sample)    w_state_next = r_din_s ? c_S_IDLE : c_S_DATA;
         c_S_DATA:   if (w_last_data) w_state_next = c_HAS_PAR ? c_S_PARITY : c_S_STOP;
         c_S_PARITY: if (w_sample)    w_state_next = c_S_STOP;
         c_S_STOP:   if (w_last_stop) w_state_next = w_frame_now ? c_S_WAIT : c_S_IDLE;
         c_S_WAIT:   if (r_din_s)     w_state_next = c_S_IDLE;
         default:                     w_state_next = c_S_IDLE;
      endcase
   end

   // Start bit is checked at its centre; later bits a full period apart.
   always_comb begin
      w_sample = 1'b0;
      case (r_state)
         c_S_START:                      w_sample = (r_cnt == c_HALF_M1);
         c_S_DATA, c_S_PARITY, c_S_STOP: w_sample = (r_cnt == c_FULL_M1);
         default:                        w_sample = 1'b0;
      endcase
      w_last_data = w_sample && (r_state == c_S_DATA) && (r_bit_cnt == c_LAST_DATA);
      w_last_stop = w_sample && (r_state == c_S_STOP) && (r_bit_cnt == c_LAST_STOP);
      w_frame_now = r_stop_err | ~r_din_s;
   end

   always_ff @(posedge baud_clk or negedge reset) begin
      if (!reset) begin
         r_sync1     <= 1'b1;
         r_din_s     <= 1'b1;
         r_cnt       <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_stop_err  <= 1'b0;
         r_perr_pend <= 1'b0;
         r_ferr_pend <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_sync1 <= din;
         r_din_s <= r_sync1;
         r_done  <= w_last_stop;

         if (w_sample || (w_state_next != r_state) ||
             (r_state == c_S_IDLE) || (r_state == c_S_WAIT)) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (w_state_next != r_state) begin
            r_bit_cnt <= '0;
         end else if (w_sample) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end

         if (w_sample && (r_state == c_S_DATA)) begin
            r_shift <= {r_din_s, r_shift[DATA_BITS-1:1]};
         end

         if (r_state != c_S_STOP) begin
            r_stop_err <= 1'b0;
         end else if (w_sample) begin
            r_stop_err <= w_frame_now;
         end

         if (r_state == c_S_START) begin
            r_perr_pend <= 1'b0;
         end else if (w_sample && (r_state == c_S_PARITY)) begin
            r_perr_pend <= ((^r_shift) ^ r_din_s) != c_ODD;
         end

         if (w_last_stop) begin
            r_ferr_pend <= w_frame_now;
         end
      end
   end

   // Completion beats a coincident read: the new byte stays valid, no overrun.
   always_ff @(posedge baud_clk or negedge reset) begin
      if (!reset) begin
         out          <= '0;
         recieve_flag <= 1'b0;
         data_valid   <= 1'b0;
         parity_err   <= 1'b0;
         frame_err    <= 1'b0;
         overrun_err  <= 1'b0;
      end else begin
         recieve_flag <= r_done;
         if (r_done) begin
            out         <= r_shift;
            parity_err  <= r_perr_pend;
            frame_err   <= r_ferr_pend;
            data_valid  <= 1'b1;
            overrun_err <= rd_en ? 1'b0 : (overrun_err | data_valid);
         end else if (rd_en) begin
            data_valid  <= 1'b0;
            overrun_err <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cfg
// Purpose  : Self-checking bench for uart_rx_cfg in three configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

   localparam int c_OS  = 16;
   localparam int c_BIG = 1 << 30;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       din0, din1, din2, rd0, rd1, rd2;
   logic [7:0] out0, out1;
   logic [6:0] out2;
   logic       fl0, fl1, fl2, dv0, dv1, dv2;
   logic       pe0, pe1, pe2, fe0, fe1, fe2, oe0, oe1, oe2;

   uart_rx_cfg u_def (
      .baud_clk(clk), .reset(rst_n), .din(din0), .rd_en(rd0), .out(out0),
      .recieve_flag(fl0), .data_valid(dv0), .parity_err(pe0),
      .frame_err(fe0), .overrun_err(oe0));

   uart_rx_cfg #(.PARITY(2)) u_par (
      .baud_clk(clk), .reset(rst_n), .din(din1), .rd_en(rd1), .out(out1),
      .recieve_flag(fl1), .data_valid(dv1), .parity_err(pe1),
      .frame_err(fe1), .overrun_err(oe1));

   uart_rx_cfg #(.DATA_BITS(7), .STOP_BITS(2)) u_d7 (
      .baud_clk(clk), .reset(rst_n), .din(din2), .rd_en(rd2), .out(out2),
      .recieve_flag(fl2), .data_valid(dv2), .parity_err(pe2),
      .frame_err(fe2), .overrun_err(oe2));

   int checks = 0;
   int errors = 0;

   int   cyc = 0;
   int   flag_cnt  [3] = '{0, 0, 0};
   int   flag_cyc  [3] = '{0, 0, 0};
   int   flag_long [3] = '{0, 0, 0};
   logic prev_flag [3] = '{1'b0, 1'b0, 1'b0};

   // Reference model state: what the consumer should currently see.
   logic [8:0] m_out [3];
   logic       m_pe [3], m_fe [3], m_dv [3], m_oe [3];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : p_mon
      logic f [3];
      f[0] = fl0; f[1] = fl1; f[2] = fl2;
      for (int i = 0; i < 3; i++) begin
         if (f[i]) begin
            if (prev_flag[i]) flag_long[i]++;
            else begin
               flag_cnt[i]++;
               flag_cyc[i] = cyc;
            end
         end
         prev_flag[i] = f[i];
      end
   end

   function automatic int nb(input int d); return (d == 2) ? 7 : 8; endfunction
   function automatic int pm(input int d); return (d == 1) ? 2 : 0; endfunction
   function automatic int ns(input int d); return (d == 2) ? 2 : 1; endfunction

   // 2 cycles of synchroniser, 1 for IDLE to react, half a bit, N bits, completion.
   function automatic int lat_exp(input int d);
      return 3 + c_OS / 2 + c_OS * (nb(d) + ((pm(d) != 0) ? 1 : 0) + ns(d)) + 1;
   endfunction

   function automatic logic [13:0] obs(input int d);
      case (d)
         0:       obs = {1'b0, out0, fl0, pe0, fe0, dv0, oe0};
         1:       obs = {1'b0, out1, fl1, pe1, fe1, dv1, oe1};
         default: obs = {2'b0, out2, fl2, pe2, fe2, dv2, oe2};
      endcase
   endfunction

   function automatic logic [13:0] exp_now(input int d);
      return {m_out[d], 1'b0, m_pe[d], m_fe[d], m_dv[d], m_oe[d]};
   endfunction

   // Correct parity makes the ones-count odd (PARITY=1) or even (PARITY=2).
   function automatic logic par_bit(input int d, input logic [8:0] dm, input bit flip);
      return (($countones(dm) % 2) == 1) ^ (pm(d) == 1) ^ flip;
   endfunction

   task automatic set_line(input int d, input logic lvl, input logic rd);
      case (d)
         0:       begin din0 = lvl; rd0 = rd; end
         1:       begin din1 = lvl; rd1 = rd; end
         default: begin din2 = lvl; rd2 = rd; end
      endcase
   endtask

   task automatic model_clear();
      for (int d = 0; d < 3; d++) begin
         m_out[d] = '0; m_pe[d] = 1'b0; m_fe[d] = 1'b0; m_dv[d] = 1'b0; m_oe[d] = 1'b0;
      end
   endtask

   task automatic model_frame(input int d, input logic [8:0] data, input bit flip,
                              input logic [1:0] stop_v, input bit rd_hit);
      logic [8:0] dm;
      int         ones;
      dm = '0;
      for (int i = 0; i < nb(d); i++) dm[i] = data[i];
      ones = $countones(dm);
      if (pm(d) == 0) m_pe[d] = 1'b0;
      else m_pe[d] = ((ones + int'(par_bit(d, dm, flip))) % 2) != ((pm(d) == 1) ? 1 : 0);
      m_fe[d]  = (ns(d) == 1) ? !stop_v[0] : !(stop_v[0] && stop_v[1]);
      m_oe[d]  = rd_hit ? 1'b0 : (m_oe[d] | m_dv[d]);
      m_dv[d]  = 1'b1;
      m_out[d] = dm;
   endtask

   task automatic rd_pulse(input int d);
      @(posedge clk); #1 set_line(d, 1'b1, 1'b1);
      @(posedge clk); #1 set_line(d, 1'b1, 1'b0);
      m_dv[d] = 1'b0;
      m_oe[d] = 1'b0;
   endtask

   task automatic send_frame(input int d, input logic [8:0] data, input bit flip,
                             input logic [1:0] stop_v, input int tail_low,
                             input int rd_at, input int abort_at, output int start_cyc);
      logic [15:0] fb;
      logic [8:0]  dm;
      logic        lvl;
      int          idx, len, total;
      dm = '0;
      for (int i = 0; i < nb(d); i++) dm[i] = data[i];
      fb = '1;
      fb[0] = 1'b0;
      for (int i = 0; i < nb(d); i++) fb[1+i] = dm[i];
      idx = 1 + nb(d);
      if (pm(d) != 0) begin
         fb[idx] = par_bit(d, dm, flip);
         idx++;
      end
      for (int s = 0; s < ns(d); s++) fb[idx+s] = stop_v[s];
      len   = idx + ns(d);
      total = c_OS * len + tail_low + c_OS;
      @(posedge clk); #1;
      start_cyc = cyc;
      for (int k = 0; k < total && k < abort_at; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (k < c_OS * len)                 lvl = fb[k / c_OS];
         else if (k < c_OS * len + tail_low) lvl = 1'b0;
         else                                lvl = 1'b1;
         set_line(d, lvl, k == rd_at);
      end
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (obs(d) !== 14'h0) begin
            errors++; $display("FAIL reset_hold d=%0d got %h expected %h", d, obs(d), 14'h0);
         end
      end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (5) @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (obs(d) !== exp_now(d)) begin
            errors++; $display("FAIL reset_idle d=%0d got %h expected %h", d, obs(d), exp_now(d));
         end
      end
   endtask

   task automatic test_basic();
      int sc, fc;
      logic [8:0] data;
      for (int n = 0; n < 5; n++) begin
         data = (n == 0) ? 9'h035 : 9'($urandom_range(0, 255));
         if (n > 0 && $urandom_range(0, 1) == 1) rd_pulse(0);
         fc = flag_cnt[0];
         send_frame(0, data, 1'b0, 2'b11, 0, -1, c_BIG, sc);
         model_frame(0, data, 1'b0, 2'b11, 1'b0);
         checks++;
         if (obs(0) !== exp_now(0)) begin
            errors++; $display("FAIL basic_frame n=%0d got %h expected %h", n, obs(0), exp_now(0));
         end
         checks++;
         if (flag_cnt[0] - fc != 1) begin
            errors++; $display("FAIL basic_flags n=%0d got %0d expected 1", n, flag_cnt[0] - fc);
         end
         checks++;
         if (flag_cyc[0] - sc != lat_exp(0)) begin
            errors++; $display("FAIL basic_latency n=%0d got %0d expected %0d", n, flag_cyc[0] - sc, lat_exp(0));
         end
      end
      checks++;
      if (flag_long[0] != 0) begin
         errors++; $display("FAIL flag_width got %0d extra cycles expected 0", flag_long[0]);
      end
   endtask

   task automatic test_parity();
      int sc, fc;
      logic [8:0] data;
      bit flip;
      for (int n = 0; n < 6; n++) begin
         data = (n < 2) ? 9'h0A5 : 9'($urandom_range(0, 255));
         flip = (n == 0) ? 1'b1 : (n == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) rd_pulse(1);
         fc = flag_cnt[1];
         send_frame(1, data, flip, 2'b11, 0, -1, c_BIG, sc);
         model_frame(1, data, flip, 2'b11, 1'b0);
         checks++;
         if (obs(1) !== exp_now(1)) begin
            errors++; $display("FAIL parity_frame n=%0d got %h expected %h", n, obs(1), exp_now(1));
         end
         checks++;
         if (flag_cyc[1] - sc != lat_exp(1) || flag_cnt[1] - fc != 1) begin
            errors++; $display("FAIL parity_timing n=%0d got lat %0d flags %0d expected lat %0d flags 1",
                               n, flag_cyc[1] - sc, flag_cnt[1] - fc, lat_exp(1));
         end
      end
   endtask

   task automatic test_framing();
      int sc, fc;
      logic [8:0] data;
      rd_pulse(0);
      fc = flag_cnt[0];
      send_frame(0, 9'h05A, 1'b0, 2'b00, 48, -1, c_BIG, sc);
      model_frame(0, 9'h05A, 1'b0, 2'b00, 1'b0);
      checks++;
      if (obs(0) !== exp_now(0)) begin
         errors++; $display("FAIL framing_frame got %h expected %h", obs(0), exp_now(0));
      end
      repeat (200) @(posedge clk); #1;
      checks++;
      if (flag_cnt[0] - fc != 1) begin
         errors++; $display("FAIL framing_single got %0d flags expected 1", flag_cnt[0] - fc);
      end
      data = 9'($urandom_range(0, 255));
      rd_pulse(0);
      send_frame(0, data, 1'b0, 2'b11, 0, -1, c_BIG, sc);
      model_frame(0, data, 1'b0, 2'b11, 1'b0);
      checks++;
      if (obs(0) !== exp_now(0)) begin
         errors++; $display("FAIL framing_recover got %h expected %h", obs(0), exp_now(0));
      end
   endtask

   task automatic test_glitch();
      int sc, fc;
      fc = flag_cnt[0];
      @(posedge clk); #1 set_line(0, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1 set_line(0, 1'b1, 1'b0);
      repeat (40) @(posedge clk); #1;
      checks++;
      if (flag_cnt[0] != fc || obs(0) !== exp_now(0)) begin
         errors++; $display("FAIL glitch_reject got flags %0d state %h expected flags 0 state %h",
                            flag_cnt[0] - fc, obs(0), exp_now(0));
      end
      send_frame(0, 9'h0C3, 1'b0, 2'b11, 0, -1, c_BIG, sc);
      model_frame(0, 9'h0C3, 1'b0, 2'b11, 1'b0);
      checks++;
      if (obs(0) !== exp_now(0) || flag_cnt[0] - fc != 1) begin
         errors++; $display("FAIL glitch_next got %h flags %0d expected %h flags 1",
                            obs(0), flag_cnt[0] - fc, exp_now(0));
      end
   endtask

   task automatic test_overrun();
      int sc;
      rd_pulse(0);
      send_frame(0, 9'h011, 1'b0, 2'b11, 0, -1, c_BIG, sc);
      model_frame(0, 9'h011, 1'b0, 2'b11, 1'b0);
      send_frame(0, 9'h022, 1'b0, 2'b11, 0, -1, c_BIG, sc);
      model_frame(0, 9'h022, 1'b0, 2'b11, 1'b0);
      checks++;
      if (obs(0) !== exp_now(0)) begin
         errors++; $display("FAIL overrun_set got %h expected %h", obs(0), exp_now(0));
      end
      rd_pulse(0);
      #1;
      checks++;
      if (obs(0) !== exp_now(0)) begin
         errors++; $display("FAIL overrun_clear got %h expected %h", obs(0), exp_now(0));
      end
      send_frame(0, 9'h033, 1'b0, 2'b11, 0, -1, c_BIG, sc);
      model_frame(0, 9'h033, 1'b0, 2'b11, 1'b0);
      send_frame(0, 9'h044, 1'b0, 2'b11, 0, lat_exp(0) - 1, c_BIG, sc);
      model_frame(0, 9'h044, 1'b0, 2'b11, 1'b1);
      checks++;
      if (obs(0) !== exp_now(0)) begin
         errors++; $display("FAIL read_at_completion got %h expected %h", obs(0), exp_now(0));
      end
   endtask

   task automatic test_reset_mid();
      int sc, fc;
      fc = flag_cnt[0];
      send_frame(0, 9'h0A5, 1'b0, 2'b11, 0, -1, c_OS * 4 + 8, sc);
      rst_n = 1'b0;
      #2;
      model_clear();
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (obs(d) !== 14'h0) begin
            errors++; $display("FAIL reset_async d=%0d got %h expected %h", d, obs(d), 14'h0);
         end
      end
      @(posedge clk); #1 set_line(0, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (200) @(posedge clk); #1;
      checks++;
      if (flag_cnt[0] != fc || obs(0) !== exp_now(0)) begin
         errors++; $display("FAIL reset_discard got flags %0d state %h expected flags 0 state %h",
                            flag_cnt[0] - fc, obs(0), exp_now(0));
      end
      send_frame(0, 9'h07E, 1'b0, 2'b11, 0, -1, c_BIG, sc);
      model_frame(0, 9'h07E, 1'b0, 2'b11, 1'b0);
      checks++;
      if (obs(0) !== exp_now(0)) begin
         errors++; $display("FAIL reset_then_frame got %h expected %h", obs(0), exp_now(0));
      end
   endtask

   task automatic test_d7();
      int sc, fc;
      logic [8:0] data;
      logic [1:0] sv;
      for (int n = 0; n < 4; n++) begin
         data = (n == 0) ? 9'h035 : 9'($urandom_range(0, 127));
         sv   = (n == 1) ? 2'b10 : 2'b11;
         if ($urandom_range(0, 1) == 1) rd_pulse(2);
         fc = flag_cnt[2];
         send_frame(2, data, 1'b0, sv, 0, -1, c_BIG, sc);
         model_frame(2, data, 1'b0, sv, 1'b0);
         checks++;
         if (obs(2) !== exp_now(2)) begin
            errors++; $display("FAIL d7_frame n=%0d got %h expected %h", n, obs(2), exp_now(2));
         end
         checks++;
         if (flag_cyc[2] - sc != lat_exp(2) || flag_cnt[2] - fc != 1) begin
            errors++; $display("FAIL d7_timing n=%0d got lat %0d flags %0d expected lat %0d flags 1",
                               n, flag_cyc[2] - sc, flag_cnt[2] - fc, lat_exp(2));
         end
      end
      checks++;
      if (flag_long[0] + flag_long[1] + flag_long[2] != 0) begin
         errors++; $display("FAIL flag_width_all got %0d extra cycles expected 0",
                            flag_long[0] + flag_long[1] + flag_long[2]);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      din0 = 1'b1; din1 = 1'b1; din2 = 1'b1;
      rd0  = 1'b0; rd1  = 1'b0; rd2  = 1'b0;
      model_clear();
      repeat (3) @(posedge clk); #1;
      test_reset();
      test_basic();
      test_parity();
      test_framing();
      test_glitch();
      test_overrun();
      test_reset_mid();
      test_d7();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
